ttl_74148_irq_enc: RTL and testbench
====================================

# ttl_74148_irq_enc

Clocked 8-line-to-3-line priority encoder with latched requests and acknowledge handshake, modelled on 74148 + 74279 interrupt-encoding logic. Collects active-low request lines from board logic (vblank, sound, coin, sub-CPU), holds them pending, and presents the highest-priority pending line as an active-low binary code for CPU interrupt-level inputs. The counterpart to the 74138-style decoders: it turns one-of-N lines back into a code, and it clears each request on CPU acknowledge.

## Interface
- WIDTH_IN, 8, number of request lines; index WIDTH_IN-1 is highest priority
- WIDTH_OUT, $clog2(WIDTH_IN), code width

- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- EI_bar  in  1  enable input (74148 pin 5), active low, synchronous to clk
- I_bar  in  WIDTH_IN  request lines, active low, asynchronous to clk
- Ack_bar  in  1  acknowledge strobe, active low, synchronous to clk
- A_bar  out  WIDTH_OUT  registered code of highest pending line, inverted (74148 A2..A0)
- GS_bar  out  1  registered group select; low when EI_bar low and any line pending
- EO_bar  out  1  registered enable output; low when EI_bar low and nothing pending
- Pending  out  WIDTH_IN  pending register, active high, for debug

## Operation
- Input path: two-flop synchronizer s1, s2 per line, plus s3 = previous s2; all reset to 1 (inactive).
- Request event for line i: s3[i]=1 and s2[i]=0 (falling edge). Event sets Pending[i].
- Acknowledge event: Ack_bar=0 this cycle and ack_prev=1 (ack_prev reset to 1). Holding Ack_bar low clears only once.
- Acknowledge clears Pending[k], k = ~A_bar (the currently presented code), only if GS_bar=0. Otherwise ignored.
- Set and clear on the same bit in the same cycle: set wins.
- Encoder, registered every cycle:
  - EI_bar=1: A_bar all ones, GS_bar=1, EO_bar=1.
  - EI_bar=0, Pending≠0: A_bar = ~(index of highest set bit), GS_bar=0, EO_bar=1.
  - EI_bar=0, Pending=0: A_bar all ones, GS_bar=1, EO_bar=0.
- Pending is kept while EI_bar=1. Acks are ignored then because GS_bar=1.
- Reset values: s1,s2,s3 all ones, ack_prev=1, Pending=0, A_bar all ones, GS_bar=1, EO_bar=1.
- Reset asserted mid-operation clears all pending requests immediately.
- A line still held low at reset release produces a fresh edge through the synchronizer and becomes pending.

## Timing
- I_bar falling between edges 0 and 1 -> s2 low after edge 2 -> Pending set at edge 3 -> A_bar/GS_bar valid after edge 4. Latency is 4 clocks.
- Ack_bar sampled low at edge N (ack_prev=1) -> Pending bit cleared at edge N -> outputs reflect the next-highest line after edge N+1.
- EI_bar change at edge N -> outputs follow after edge N (1 clock).
- Pulses on I_bar shorter than one clock period may be missed. Sources must hold a request for at least 2 clocks.

## Configuration
- TTL74148_EDGE_LATCH_EN defined: edge-latched pending with acknowledge, as described above.
- Not defined: level mode. Pending = ~s2 combinationally, and s3 and ack_prev are not built. Ack_bar has no effect. Input-to-output latency is 3 clocks. A request stays visible exactly while I_bar is held low (after synchronizer delay).

## Test plan
- Reset with I_bar=8'hFF, EI_bar=0 -> A_bar=3'b111, GS_bar=1, EO_bar=1 during reset; EO_bar=0 one clock after release.
- I_bar[2] pulsed low for 3 clocks, EI_bar=0 -> 4 clocks later A_bar=3'b101, GS_bar=0, EO_bar=1. Code stays set after the line returns high (edge mode).
- Lines 1 and 6 pending -> A_bar=3'b001. Ack_bar low for 5 clocks -> only line 6 clears, A_bar=3'b110. Second Ack_bar pulse -> GS_bar=1, EO_bar=0.
- New edge on line 6 in the same cycle as the ack of line 6 -> Pending[6] remains 1, A_bar stays 3'b001.
- Line 4 pending, EI_bar=1 -> outputs all ones and Ack_bar ignored. EI_bar back to 0 -> A_bar=3'b011 next clock. Reset asserted -> Pending=0 immediately.
- Macro undefined: hold I_bar[5] low -> A_bar=3'b010 after 3 clocks. Release -> GS_bar=1 after 3 clocks. Ack_bar has no effect.

Source files
------------

// File: rtl/ttl_74148_irq_enc_if.sv
// Request/encoded-code bundle for ttl_74148_irq_enc: board request lines and enable
// in, inverted priority code plus group-select/enable-out and debug pending out.
interface ttl_74148_irq_enc_if #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = $clog2(WIDTH_IN)
);
  // Handshake: the CPU acknowledges the presented code by driving Ack_bar low.
  // Only the high-to-low transition counts, and only while GS_bar is low; the
  // line named by ~A_bar is then retired. A held-low Ack_bar retires one line.
  logic                 EI_bar;
  logic [WIDTH_IN-1:0]  I_bar;
  logic                 Ack_bar;
  logic [WIDTH_OUT-1:0] A_bar;
  logic                 GS_bar;
  logic                 EO_bar;
  logic [WIDTH_IN-1:0]  Pending;

  modport master (
    output EI_bar, I_bar, Ack_bar,
    input  A_bar, GS_bar, EO_bar, Pending
  );

  modport slave (
    input  EI_bar, I_bar, Ack_bar,
    output A_bar, GS_bar, EO_bar, Pending
  );
endinterface

// File: rtl/ttl_74148_irq_enc.sv
// Clocked 74148-style priority encoder for interrupt requests. Define
// TTL74148_EDGE_LATCH_EN for edge-latched pending lines with acknowledge; otherwise level mode.
module ttl_74148_irq_enc #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = $clog2(WIDTH_IN)
) (
  input logic               clk,
  input logic               reset_n,
  ttl_74148_irq_enc_if.slave bus
);

  logic [WIDTH_IN-1:0]  s1;
  logic [WIDTH_IN-1:0]  s2;
  logic [WIDTH_IN-1:0]  pending;
  logic [WIDTH_OUT-1:0] hi_idx;
  logic [WIDTH_OUT-1:0] a_bar;
  logic                 gs_bar;
  logic                 eo_bar;

  // Request lines are asynchronous; two flops before anything looks at them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= bus.I_bar;
      s2 <= s1;
    end
  end

`ifdef TTL74148_EDGE_LATCH_EN
  logic [WIDTH_IN-1:0]  s3;
  logic [WIDTH_IN-1:0]  req_set;
  logic [WIDTH_IN-1:0]  ack_clr;
  logic [WIDTH_OUT-1:0] ack_idx;
  logic                 ack_prev;
  logic                 ack_evt;

  always_comb begin
    req_set = s3 & ~s2;
    ack_evt = ~bus.Ack_bar & ack_prev;
    ack_idx = ~a_bar;
    ack_clr = '0;
    if (ack_evt && !gs_bar) ack_clr[ack_idx] = 1'b1;
  end

  // Set is OR-ed in after the clear so a fresh request beats its own acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3       <= '1;
      ack_prev <= 1'b1;
      pending  <= '0;
    end else begin
      s3       <= s2;
      ack_prev <= bus.Ack_bar;
      pending  <= (pending & ~ack_clr) | req_set;
    end
  end
`else
  logic unused_ack;

  assign pending    = ~s2;
  assign unused_ack = bus.Ack_bar;
`endif

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      if (pending[i]) hi_idx = WIDTH_OUT'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_bar  <= '1;
      gs_bar <= 1'b1;
      eo_bar <= 1'b1;
    end else if (bus.EI_bar) begin
      a_bar  <= '1;
      gs_bar <= 1'b1;
      eo_bar <= 1'b1;
    end else if (|pending) begin
      a_bar  <= ~hi_idx;
      gs_bar <= 1'b0;
      eo_bar <= 1'b1;
    end else begin
      a_bar  <= '1;
      gs_bar <= 1'b1;
      eo_bar <= 1'b0;
    end
  end

  assign bus.A_bar   = a_bar;
  assign bus.GS_bar  = gs_bar;
  assign bus.EO_bar  = eo_bar;
  assign bus.Pending = pending;

endmodule

// File: tb/tb_ttl_74148_irq_enc.sv
// Directed bench for ttl_74148_irq_enc; covers whichever mode the build selects
// via TTL74148_EDGE_LATCH_EN.
module tb_ttl_74148_irq_enc;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  ttl_74148_irq_enc_if #(.WIDTH_IN(8)) bus ();

  ttl_74148_irq_enc #(.WIDTH_IN(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and park on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] outs();
    return {11'd0, bus.A_bar, bus.GS_bar, bus.EO_bar};
  endfunction

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    bus.I_bar   = 8'hFF;
    bus.EI_bar  = 1'b0;
    bus.Ack_bar = 1'b1;
    cyc(3);
    check("reset_outs", outs(), {11'd0, 3'b111, 1'b1, 1'b1});
    check("reset_pending", {8'd0, bus.Pending}, 16'h0000);
    reset_n = 1'b1;
    cyc(1);
    check("idle_eo", outs(), {11'd0, 3'b111, 1'b1, 1'b0});

`ifdef TTL74148_EDGE_LATCH_EN
    // Line 2 pulsed for 3 clocks
    bus.I_bar = 8'b1111_1011;
    cyc(3);
    bus.I_bar = 8'hFF;
    check("l2_before_latency", outs(), {11'd0, 3'b111, 1'b1, 1'b0});
    cyc(1);
    check("l2_code", outs(), {11'd0, 3'b101, 1'b0, 1'b1});
    cyc(4);
    check("l2_held_after_release", outs(), {11'd0, 3'b101, 1'b0, 1'b1});
    check("l2_pending", {8'd0, bus.Pending}, 16'h0004);
    bus.Ack_bar = 1'b0;
    cyc(1);
    bus.Ack_bar = 1'b1;
    check("l2_ack_pending", {8'd0, bus.Pending}, 16'h0000);
    cyc(1);
    check("l2_ack_outs", outs(), {11'd0, 3'b111, 1'b1, 1'b0});

    // Lines 1 and 6, long acknowledge retires only the top one
    bus.I_bar = 8'b1011_1101;
    cyc(3);
    bus.I_bar = 8'hFF;
    cyc(2);
    check("l16_code", outs(), {11'd0, 3'b001, 1'b0, 1'b1});
    check("l16_pending", {8'd0, bus.Pending}, 16'h0042);
    bus.Ack_bar = 1'b0;
    cyc(5);
    check("long_ack_pending", {8'd0, bus.Pending}, 16'h0002);
    check("long_ack_code", outs(), {11'd0, 3'b110, 1'b0, 1'b1});
    bus.Ack_bar = 1'b1;
    cyc(1);
    bus.Ack_bar = 1'b0;
    cyc(1);
    bus.Ack_bar = 1'b1;
    check("second_ack_pending", {8'd0, bus.Pending}, 16'h0000);
    cyc(1);
    check("second_ack_outs", outs(), {11'd0, 3'b111, 1'b1, 1'b0});

    // New edge on line 6 lands on the same edge as its acknowledge
    bus.I_bar = 8'b1011_1111;
    cyc(3);
    bus.I_bar = 8'hFF;
    cyc(3);
    check("l6_code", outs(), {11'd0, 3'b001, 1'b0, 1'b1});
    bus.I_bar = 8'b1011_1111;
    cyc(2);
    bus.Ack_bar = 1'b0;
    cyc(1);
    bus.Ack_bar = 1'b1;
    bus.I_bar   = 8'hFF;
    check("set_wins_pending", {8'd0, bus.Pending}, 16'h0040);
    cyc(1);
    check("set_wins_code", outs(), {11'd0, 3'b001, 1'b0, 1'b1});
    bus.Ack_bar = 1'b0;
    cyc(1);
    bus.Ack_bar = 1'b1;
    check("l6_cleanup", {8'd0, bus.Pending}, 16'h0000);
    cyc(2);

    // Line 4 while disabled
    bus.I_bar = 8'b1110_1111;
    cyc(3);
    bus.I_bar = 8'hFF;
    cyc(2);
    check("l4_code", outs(), {11'd0, 3'b011, 1'b0, 1'b1});
    bus.EI_bar = 1'b1;
    cyc(1);
    check("ei_high_outs", outs(), {11'd0, 3'b111, 1'b1, 1'b1});
    bus.Ack_bar = 1'b0;
    cyc(1);
    bus.Ack_bar = 1'b1;
    cyc(1);
    check("ei_high_ack_ignored", {8'd0, bus.Pending}, 16'h0010);
    bus.EI_bar = 1'b0;
    cyc(1);
    check("ei_low_again", outs(), {11'd0, 3'b011, 1'b0, 1'b1});
    bus.I_bar = 8'b1111_0111;
    #1 reset_n = 1'b0;
    #1;
    check("midreset_pending", {8'd0, bus.Pending}, 16'h0000);
    check("midreset_outs", outs(), {11'd0, 3'b111, 1'b1, 1'b1});
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    check("held_at_release_early", outs(), {11'd0, 3'b111, 1'b1, 1'b0});
    cyc(1);
    check("held_at_release_code", outs(), {11'd0, 3'b100, 1'b0, 1'b1});
    bus.I_bar = 8'hFF;
`else
    // Level mode: line 5 held
    bus.I_bar = 8'b1101_1111;
    cyc(2);
    check("l5_before_latency", outs(), {11'd0, 3'b111, 1'b1, 1'b0});
    cyc(1);
    check("l5_code", outs(), {11'd0, 3'b010, 1'b0, 1'b1});
    check("l5_pending", {8'd0, bus.Pending}, 16'h0020);
    bus.Ack_bar = 1'b0;
    cyc(2);
    bus.Ack_bar = 1'b1;
    check("l5_ack_no_effect_pending", {8'd0, bus.Pending}, 16'h0020);
    check("l5_ack_no_effect_code", outs(), {11'd0, 3'b010, 1'b0, 1'b1});
    bus.I_bar = 8'hFF;
    cyc(2);
    check("l5_release_early", outs(), {11'd0, 3'b010, 1'b0, 1'b1});
    cyc(1);
    check("l5_release_done", outs(), {11'd0, 3'b111, 1'b1, 1'b0});

    // Lines 7, 4, 1 held together
    bus.I_bar = 8'b0110_1101;
    cyc(3);
    check("l741_code", outs(), {11'd0, 3'b000, 1'b0, 1'b1});
    check("l741_pending", {8'd0, bus.Pending}, 16'h0092);
    bus.EI_bar = 1'b1;
    cyc(1);
    check("ei_high_outs", outs(), {11'd0, 3'b111, 1'b1, 1'b1});
    bus.EI_bar = 1'b0;
    cyc(1);
    check("ei_low_again", outs(), {11'd0, 3'b000, 1'b0, 1'b1});
    bus.I_bar = 8'b1110_1101;
    cyc(3);
    check("l41_code", outs(), {11'd0, 3'b011, 1'b0, 1'b1});
    #1 reset_n = 1'b0;
    #1;
    check("midreset_pending", {8'd0, bus.Pending}, 16'h0000);
    check("midreset_outs", outs(), {11'd0, 3'b111, 1'b1, 1'b1});
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    check("held_at_release_code", outs(), {11'd0, 3'b011, 1'b0, 1'b1});
    bus.I_bar = 8'hFF;
`endif

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
